skein512_ubi_iter: RTL and testbench
====================================

SKEIN512_UBI_ITER -- requirements
Module: skein512_ubi_iter

Interface
REQ-001 SHALL have parameter ROUNDS_PER_CYCLE, default 4, Threefish mix rounds per clock; legal values 1, 2, 4, 8.
REQ-002 SHALL have parameter NUM_ROUNDS, default 72, total Threefish rounds; a multiple of 8 and of ROUNDS_PER_CYCLE.
REQ-003 SHALL stop elaboration with an error for any illegal parameter value.
REQ-004 SHALL have port clk, input, 1, the only clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1, request carries a valid block.
REQ-007 SHALL have port in_ready, output, 1, block can be accepted.
REQ-008 SHALL have port key, input, 512, chaining value; word i is at [511-64i -: 64].
REQ-009 SHALL have port tweak, input, 128, t0 is [127:64] and t1 is [63:0].
REQ-010 SHALL have port msg, input, 512, message block; word order as for key.
REQ-011 SHALL have port out_valid, output, 1, out_hash is valid.
REQ-012 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-013 SHALL have port out_hash, output, 512, UBI output; word order as for key.
REQ-014 SHALL have port busy, output, 1, high in RUN and in DONE.

Function
REQ-015 SHALL accept a block on a clock edge where in_valid and in_ready are both high; key, tweak and msg are captured only at that edge.
REQ-016 SHALL use the FSM states IDLE, RUN and DONE; transitions are IDLE->RUN on accept, RUN->DONE after the final round cycle, and DONE->IDLE on out_valid and out_ready both high.
REQ-017 SHALL drive in_ready high only in IDLE; out_valid high only in DONE.
REQ-018 SHALL compute k8 = 0x1BD11BDAA9FC1A22 ^ k0 ^ ... ^ k7, and t2 = t0 ^ t1.
REQ-019 SHALL form subkey s as follows: word i = k[(s+i) mod 9], plus t[s mod 3] on word 5, plus t[(s+1) mod 3] on word 6, plus s on word 7; all arithmetic is mod 2^64.
REQ-020 SHALL inject subkey 0 in the accept cycle, and inject subkey s after each completed round 4s-1; with ROUNDS_PER_CYCLE=8 this means two injections per cycle.
REQ-021 SHALL implement the mix as y0 = x0 + x1 and y1 = (x1 rotl R) ^ y0, applied to pairs (0,1), (2,3), (4,5), (6,7), followed by permutation 2,1,4,7,6,5,0,3.
REQ-022 SHALL use these rotation constants R, indexed by round mod 8, per pair: 46 36 19 37 / 33 27 14 42 / 17 49 36 39 / 44 9 54 56 / 39 30 34 24 / 13 50 10 17 / 25 29 39 43 / 8 35 56 22.
REQ-023 SHALL compute out_hash = (final state + subkey NUM_ROUNDS/4) ^ msg, and register it on entry to DONE.
REQ-024 SHALL assert out_valid exactly NUM_ROUNDS/ROUNDS_PER_CYCLE + 1 cycles after the accept edge; this is 19 cycles for the default parameters.
REQ-025 SHALL hold out_hash and out_valid stable in DONE while out_ready is low, for any duration.
REQ-026 SHALL ignore in_valid and all input changes outside IDLE.
REQ-027 SHALL NOT accept a new block in the cycle of the output handshake; the next accept is possible at the earliest one cycle later, from IDLE.
REQ-028 SHALL use a round counter that saturates at its terminal value and never wraps into a second pass.

Reset
REQ-029 SHALL, on rst high at a clock edge, enter IDLE with in_ready=1, out_valid=0, busy=0 and out_hash=0.
REQ-030 SHALL, on rst in RUN or DONE, abandon the block with no out_valid for it; an in_valid coinciding with rst is not accepted.
REQ-031 SHALL make in_ready high again on the first edge after rst is released.

Verification
REQ-032 SHALL cover: all-zero key, tweak and msg, default parameters -> out_valid exactly 19 cycles after accept, with word 0 of out_hash = 0xBC2560EFC6BBA2B1, matching the golden model.
REQ-033 SHALL cover: random key, tweak and msg with ROUNDS_PER_CYCLE set to 1, 2, 4 and 8 -> identical out_hash in all four builds, with latency of 73, 37, 19 and 10 cycles respectively.
REQ-034 SHALL cover: out_ready held low for 5 cycles in DONE -> out_valid stays 1, out_hash is unchanged and in_ready stays 0; then IDLE one cycle after the handshake.
REQ-035 SHALL cover: rst asserted in cycle 7 of RUN -> the next cycle has out_valid=0 and in_ready=1, and a new block then yields the golden result.
REQ-036 SHALL cover: msg and key toggled every cycle during RUN -> out_hash equals the golden result for the values captured at accept.
REQ-037 SHALL cover: in_valid held high continuously with out_ready=1 -> one accept every L+2 cycles, with no dropped and no duplicated results.

Source files
------------

// File: rtl/skein512_ubi_iter.sv
// ---------------------------------------------------------------------------
// skein512_ubi_iter
//   Iterative Skein-512 UBI block compression: one Threefish-512 encryption
//   of a message block under a chaining value and tweak, followed by the
//   feed-forward XOR with the message. ROUNDS_PER_CYCLE Threefish rounds are
//   unrolled per clock; subkeys are derived on the fly from the stored
//   extended key and tweak.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   request carries a block      in_ready  block can be accepted
//   key[512]   chaining value, word i at [511-64i -: 64]
//   tweak[128] t0 = [127:64], t1 = [63:0]
//   msg[512]   message block, same word order as key
//   out_valid  out_hash is valid            out_ready consumer accepts
//   out_hash   UBI output, same word order as key
//   busy       high while a block is being processed or held for output
// ---------------------------------------------------------------------------
module skein512_ubi_iter #(
  parameter int ROUNDS_PER_CYCLE = 4,
  parameter int NUM_ROUNDS       = 72
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] key,
  input  logic [127:0] tweak,
  input  logic [511:0] msg,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_hash,
  output logic         busy
);

  // Parameter legality is checked at elaboration time.
  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
        ROUNDS_PER_CYCLE == 4 || ROUNDS_PER_CYCLE == 8)) begin : g_bad_rpc
    $error("skein512_ubi_iter: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
  end
  if (NUM_ROUNDS <= 0 || (NUM_ROUNDS % 8) != 0 ||
      (ROUNDS_PER_CYCLE > 0 && (NUM_ROUNDS % ROUNDS_PER_CYCLE) != 0)) begin : g_bad_rounds
    $error("skein512_ubi_iter: NUM_ROUNDS must be a positive multiple of 8 and of ROUNDS_PER_CYCLE");
  end

  localparam int NUM_CYCLES = (ROUNDS_PER_CYCLE > 0) ? NUM_ROUNDS / ROUNDS_PER_CYCLE : 1;
  localparam int CW         = $clog2(NUM_CYCLES + 1);

  // Index 0 sits at the MSB end, so a 512-bit port casts straight to words.
  typedef logic [0:7][63:0] blk_t;
  typedef logic [0:8][63:0] kw_t;
  typedef logic [0:2][63:0] tw_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [63:0] KS_PARITY = 64'h1BD11BDAA9FC1A22;

  // Rotation constants, row = round mod 8, column = word pair.
  localparam logic [0:31][5:0] ROT = {
    6'd46, 6'd36, 6'd19, 6'd37,
    6'd33, 6'd27, 6'd14, 6'd42,
    6'd17, 6'd49, 6'd36, 6'd39,
    6'd44, 6'd9,  6'd54, 6'd56,
    6'd39, 6'd30, 6'd34, 6'd24,
    6'd13, 6'd50, 6'd10, 6'd17,
    6'd25, 6'd29, 6'd39, 6'd43,
    6'd8,  6'd35, 6'd56, 6'd22
  };

  // Word permutation applied after each mix layer: new[i] = old[PERM[i]].
  localparam logic [0:7][2:0] PERM = {3'd2, 3'd1, 3'd4, 3'd7, 3'd6, 3'd5, 3'd0, 3'd3};

  function automatic logic [63:0] rotl(input logic [63:0] x, input logic [5:0] n);
    return (x << n) | (x >> (7'd64 - {1'b0, n}));
  endfunction

  function automatic blk_t add_words(input blk_t a, input blk_t b);
    blk_t r;
    for (int i = 0; i < 8; i++) r[i] = a[i] + b[i];
    return r;
  endfunction

  // Subkey s from the 9-word extended key and 3-word extended tweak.
  function automatic blk_t subkey(input kw_t k, input tw_t t, input int s);
    blk_t       r;
    logic [3:0] ki;
    logic [1:0] ta;
    logic [1:0] tb;
    for (int i = 0; i < 8; i++) begin
      ki   = 4'((s + i) % 9);
      r[i] = k[ki];
    end
    ta   = 2'(s % 3);
    tb   = 2'((s + 1) % 3);
    r[5] = r[5] + t[ta];
    r[6] = r[6] + t[tb];
    r[7] = r[7] + 64'(s);
    return r;
  endfunction

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  kw_t           kw_reg;
  tw_t           tw_reg;
  blk_t          msg_reg;
  blk_t          st_reg;

  // Extended key/tweak formed directly from the ports for the accept cycle.
  kw_t kw_in;
  tw_t tw_in;
  always_comb begin
    logic [63:0] par;
    par = KS_PARITY;
    for (int i = 0; i < 8; i++) par = par ^ key[511 - 64*i -: 64];
    kw_in = {key, par};
    tw_in = {tweak, tweak[127:64] ^ tweak[63:0]};
  end

  // Unrolled round chain. stage[0] is the registered state, stage[n] is the
  // state after n rounds of this cycle (including any subkey injected after
  // a round whose absolute number is 3 mod 4).
  logic [ROUNDS_PER_CYCLE:0][0:7][63:0] stage;
  assign stage[0] = st_reg;

  for (genvar gi = 0; gi < ROUNDS_PER_CYCLE; gi++) begin : g_round
    blk_t mixed;
    blk_t permuted;
    blk_t injected;
    int   rnum;

    always_comb begin
      rnum  = int'(cnt_reg) * ROUNDS_PER_CYCLE + gi;
      mixed = stage[gi];
      for (int p = 0; p < 4; p++) begin
        mixed[2*p]   = stage[gi][2*p] + stage[gi][2*p+1];
        mixed[2*p+1] = rotl(stage[gi][2*p+1], ROT[{rnum[2:0], p[1:0]}]) ^ mixed[2*p];
      end
      permuted = mixed;
      for (int i = 0; i < 8; i++) permuted[i] = mixed[PERM[i]];
      injected = permuted;
      if (rnum[1:0] == 2'b11)
        injected = add_words(permuted, subkey(kw_reg, tw_reg, (rnum >> 2) + 1));
    end

    assign stage[gi+1] = injected;
  end

  // Control FSM with registered handshake outputs. The round counter runs
  // 0..NUM_CYCLES and sticks at NUM_CYCLES; the cycle spent there forms the
  // feed-forward and moves to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_hash  <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            kw_reg    <= kw_in;
            tw_reg    <= tw_in;
            msg_reg   <= blk_t'(msg);
            st_reg    <= add_words(blk_t'(msg), subkey(kw_in, tw_in, 0));
            cnt_reg   <= '0;
            state_reg <= S_RUN;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
          end
        end
        S_RUN: begin
          if (cnt_reg == CW'(NUM_CYCLES)) begin
            out_hash  <= st_reg ^ msg_reg;
            out_valid <= 1'b1;
            state_reg <= S_DONE;
          end else begin
            st_reg  <= stage[ROUNDS_PER_CYCLE];
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_reg <= S_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_skein512_ubi_iter.sv
// ---------------------------------------------------------------------------
// tb_skein512_ubi_iter
//   Self-checking bench for skein512_ubi_iter. A default-parameter instance
//   carries most of the scenarios; three more instances built with 1, 2 and
//   8 rounds per cycle share the data inputs and are compared against the
//   same reference. The reference is a plain Threefish-512/UBI model.
// ---------------------------------------------------------------------------
module tb_skein512_ubi_iter;

  localparam int ALT_RPC [3] = '{1, 2, 8};
  localparam int ALT_LAT [3] = '{73, 37, 10};
  localparam int LAT     = 19;

  localparam int ROT [32] = '{46, 36, 19, 37, 33, 27, 14, 42, 17, 49, 36, 39,
                              44, 9, 54, 56, 39, 30, 34, 24, 13, 50, 10, 17,
                              25, 29, 39, 43, 8, 35, 56, 22};
  localparam int PERM [8] = '{2, 1, 4, 7, 6, 5, 0, 3};

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] key;
  logic [127:0] tweak;
  logic [511:0] msg;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] out_hash;
  logic         busy;

  logic [2:0]         a_iv;
  logic [2:0]         a_ir;
  logic [2:0]         a_ov;
  logic [2:0]         a_or;
  logic [2:0]         a_busy;
  logic [2:0][511:0]  a_oh;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  skein512_ubi_iter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .key(key), .tweak(tweak), .msg(msg), .out_valid(out_valid),
    .out_ready(out_ready), .out_hash(out_hash), .busy(busy)
  );

  for (genvar gi = 0; gi < 3; gi++) begin : g_alt
    skein512_ubi_iter #(.ROUNDS_PER_CYCLE(ALT_RPC[gi])) u_alt (
      .clk(clk), .rst(rst), .in_valid(a_iv[gi]), .in_ready(a_ir[gi]),
      .key(key), .tweak(tweak), .msg(msg), .out_valid(a_ov[gi]),
      .out_ready(a_or[gi]), .out_hash(a_oh[gi]), .busy(a_busy[gi])
    );
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] rotl64(input logic [63:0] x, input int n);
    return (x << n) | (x >> (64 - n));
  endfunction

  function automatic logic [511:0] ubi_ref(input logic [511:0] k, input logic [127:0] t,
                                           input logic [511:0] m);
    logic [63:0]  kk [9];
    logic [63:0]  tt [3];
    logic [63:0]  x  [8];
    logic [63:0]  y  [8];
    logic [511:0] res;
    kk[8] = 64'h1BD11BDAA9FC1A22;
    for (int i = 0; i < 8; i++) begin
      kk[i] = k[511 - 64*i -: 64];
      kk[8] = kk[8] ^ kk[i];
      x[i]  = m[511 - 64*i -: 64];
    end
    tt[0] = t[127:64];
    tt[1] = t[63:0];
    tt[2] = tt[0] ^ tt[1];
    for (int r = 0; r <= 72; r++) begin
      if (r % 4 == 0) begin
        int s;
        s = r / 4;
        for (int i = 0; i < 8; i++) x[i] = x[i] + kk[(s + i) % 9];
        x[5] = x[5] + tt[s % 3];
        x[6] = x[6] + tt[(s + 1) % 3];
        x[7] = x[7] + 64'(s);
      end
      if (r == 72) break;
      for (int p = 0; p < 4; p++) begin
        y[2*p]   = x[2*p] + x[2*p+1];
        y[2*p+1] = rotl64(x[2*p+1], ROT[(r % 8) * 4 + p]) ^ y[2*p];
      end
      for (int i = 0; i < 8; i++) x[i] = y[PERM[i]];
    end
    for (int i = 0; i < 8; i++) res[511 - 64*i -: 64] = x[i] ^ m[511 - 64*i -: 64];
    return res;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic randomize_inputs();
    key   = rand512();
    msg   = rand512();
    tweak = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Present a block for one edge; returns at the negedge after the accept edge.
  task automatic start_main();
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // lat = number of edges after the accept edge until out_valid is seen.
  task automatic wait_main(input bit toggle, output int lat);
    lat = -1;
    for (int k = 0; k <= 200; k++) begin
      if (out_valid) begin
        lat = k;
        break;
      end
      if (toggle) begin
        randomize_inputs();
        in_valid = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    if (toggle) in_valid = 1'b0;
  endtask

  task automatic run_main(input string tag, input logic [511:0] exp);
    int lat;
    start_main();
    check({tag, "_busy"}, busy, 1'b1);
    wait_main(1'b0, lat);
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_hash"}, out_hash, exp);
    @(negedge clk);
    check({tag, "_idle_ready"}, {out_valid, in_ready}, 2'b01);
  endtask

  task automatic run_alt(input int a, input logic [511:0] exp);
    int lat;
    check($sformatf("alt%0d_in_ready", ALT_RPC[a]), a_ir[a], 1'b1);
    a_iv[a] = 1'b1;
    @(negedge clk);
    a_iv[a] = 1'b0;
    check($sformatf("alt%0d_busy", ALT_RPC[a]), a_busy[a], 1'b1);
    lat = -1;
    for (int k = 0; k <= 200; k++) begin
      if (a_ov[a]) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    check($sformatf("alt%0d_latency", ALT_RPC[a]), lat, ALT_LAT[a]);
    check($sformatf("alt%0d_hash", ALT_RPC[a]), a_oh[a], exp);
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [511:0] exp;
    logic [511:0] exp2;
    logic [511:0] held;
    int           lat;
    logic [511:0] exp_q [$];
    int           n_acc;
    int           n_res;
    int           last_acc;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    key = '0; tweak = '0; msg = '0;
    a_iv = '0; a_or = '1;

    // Reset state, and an in_valid coinciding with reset is not taken.
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_out_hash", out_hash, '0);
    in_valid = 1'b1;
    @(negedge clk);
    check("rst_no_accept", busy, 1'b0);
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1'b1);

    // All-zero block: known Threefish-512 word 0.
    exp = ubi_ref(key, tweak, msg);
    start_main();
    wait_main(1'b0, lat);
    check("zero_latency", lat, LAT);
    check("zero_word0", out_hash[511:448], 64'hBC2560EFC6BBA2B1);
    check("zero_hash", out_hash, exp);
    @(negedge clk);

    // Same random blocks through all four unrolling factors.
    for (int v = 0; v < 2; v++) begin
      randomize_inputs();
      exp = ubi_ref(key, tweak, msg);
      run_main($sformatf("rand%0d", v), exp);
      for (int a = 0; a < 3; a++) run_alt(a, exp);
    end

    // Output stall: result and flags hold while out_ready is low; a request
    // presented during the handshake edge waits for the following edge.
    randomize_inputs();
    exp = ubi_ref(key, tweak, msg);
    out_ready = 1'b0;
    start_main();
    wait_main(1'b0, lat);
    check("stall_latency", lat, LAT);
    check("stall_hash", out_hash, exp);
    held = out_hash;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_hold_flags", {out_valid, in_ready}, 2'b10);
      check("stall_hold_hash", out_hash, held);
    end
    randomize_inputs();
    exp2 = ubi_ref(key, tweak, msg);
    out_ready = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    check("handshake_idle", {out_valid, in_ready, busy}, 3'b010);
    @(negedge clk);
    in_valid = 1'b0;
    check("accept_after_handshake", {busy, in_ready}, 2'b10);
    wait_main(1'b0, lat);
    check("after_stall_latency", lat, LAT);
    check("after_stall_hash", out_hash, exp2);
    @(negedge clk);

    // Reset in RUN cycle 7 abandons the block; next block is unaffected.
    randomize_inputs();
    start_main();
    repeat (6) @(negedge clk);
    randomize_inputs();
    exp = ubi_ref(key, tweak, msg);
    rst = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    check("run_rst_flags", {out_valid, in_ready, busy}, 3'b010);
    rst = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    wait_main(1'b0, lat);
    check("post_run_rst_latency", lat, LAT);
    check("post_run_rst_hash", out_hash, exp);
    @(negedge clk);

    // Inputs churn every cycle after accept; result reflects the captured block.
    randomize_inputs();
    exp = ubi_ref(key, tweak, msg);
    start_main();
    wait_main(1'b1, lat);
    check("toggle_latency", lat, LAT);
    check("toggle_hash", out_hash, exp);
    @(negedge clk);

    // Back-to-back requests: one accept every LAT+2 cycles, results in order.
    n_acc = 0; n_res = 0; last_acc = -1;
    randomize_inputs();
    in_valid = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (out_valid) begin
        n_res++;
        if (exp_q.size() == 0) check("stream_spurious", exp_q.size(), 1);
        else                   check("stream_hash", out_hash, exp_q.pop_front());
      end
      if (n_acc < 5 && in_ready) begin
        exp_q.push_back(ubi_ref(key, tweak, msg));
        if (last_acc >= 0) check("stream_gap", c - last_acc, LAT + 2);
        last_acc = c;
        n_acc++;
      end else begin
        if (n_acc >= 5) in_valid = 1'b0;
        randomize_inputs();
      end
      if (n_acc >= 5 && exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("stream_results", n_res, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
